// File: rtl/inert_pkg.sv
// inert_pkg: shared types, widths and saturation helpers for inertial_integrator.
package inert_pkg;
  typedef enum logic {CAL, RUN} state_e;
  localparam int INT_W = 27;
  localparam int ACC_W = INT_W + 1;
  localparam int PROD_W = 26;
  localparam logic signed [9:0] FUS_SCALE = 10'sd327;
  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    return v[16] != v[15] ? {v[16], {15{~v[16]}}} : v[15:0];
  endfunction
  // The integrator sum fits in ACC_W bits, so overflow shows as the top two bits disagreeing.
  function automatic logic signed [INT_W-1:0] sat_int(input logic signed [ACC_W-1:0] v);
    return v[ACC_W-1] != v[ACC_W-2] ? {v[ACC_W-1], {INT_W-1{~v[ACC_W-1]}}} : v[INT_W-1:0];
  endfunction
endpackage

// File: rtl/ptch_rt_cal.sv
// ptch_rt_cal: averages 2^CAL_LOG2 gyro samples into a pitch-rate offset.
module ptch_rt_cal #(
  parameter int CAL_LOG2 = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               smp_vld_i,
  input  logic               clr_i,
  input  logic signed [15:0] raw_i,
  output logic signed [15:0] offset_o,
  output logic               cal_cmplt_o
);
  localparam int SUM_W = 16 + CAL_LOG2;
  logic signed [SUM_W-1:0] sum_q, sum_d, tot;
  logic [CAL_LOG2-1:0] cnt_q, cnt_d;
  logic signed [15:0] offset_q, offset_d;
  always_comb begin
    tot = sum_q + SUM_W'(raw_i);
    cal_cmplt_o = smp_vld_i && cnt_q == '1;
    sum_d = clr_i || cal_cmplt_o ? '0 : smp_vld_i ? tot : sum_q;
    cnt_d = clr_i ? '0 : smp_vld_i ? cnt_q + 1'b1 : cnt_q;
    offset_d = cal_cmplt_o ? 16'(tot >>> CAL_LOG2) : offset_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      cnt_q <= '0;
      offset_q <= '0;
    end else begin
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      offset_q <= offset_d;
    end
  end
  assign offset_o = offset_q;
endmodule

// File: rtl/inertial_integrator.sv
// inertial_integrator: gyro offset calibration, pitch integration and optional accel fusion.
// Define INERT_FUSION_EN to enable the accelerometer complementary-filter term.
module inertial_integrator
  import inert_pkg::*;
#(
  parameter int          CAL_LOG2    = 4,
  parameter logic [15:0] AZ_OFFSET   = 16'h00A0,
  parameter int          FUSION_GAIN = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vld,
  input  logic signed [15:0] ptch_rt_raw,
  input  logic signed [15:0] AZ,
  input  logic               cal_strt,
  output logic signed [15:0] ptch,
  output logic signed [15:0] ptch_rt,
  output logic               ptch_vld,
  output logic               cal_done
);
  state_e state_q, state_d;
  logic run, upd, cal_cmplt;
  logic signed [15:0] offset, comp, ptch_rt_q, ptch_rt_d;
  logic signed [16:0] diff;
  logic signed [INT_W-1:0] int_q, int_d, fusion;
  logic signed [ACC_W-1:0] int_sum;
  logic ptch_vld_q, ptch_vld_d;
  assign run = state_q == RUN;
  assign upd = run && vld && !cal_strt;
  ptch_rt_cal #(.CAL_LOG2(CAL_LOG2)) u_cal (
    .clk         (clk),
    .rst_n       (rst_n),
    .smp_vld_i   (!run && vld && !cal_strt),
    .clr_i       (cal_strt),
    .raw_i       (ptch_rt_raw),
    .offset_o    (offset),
    .cal_cmplt_o (cal_cmplt)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= CAL;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = cal_strt ? CAL : cal_cmplt ? RUN : state_q;
  end
  always_comb begin
    cal_done = state_q == RUN;
    ptch = int_q[INT_W-1 -: 16];
    ptch_rt = ptch_rt_q;
    ptch_vld = ptch_vld_q;
  end
`ifdef INERT_FUSION_EN
  logic signed [15:0] az_c, ptch_acc;
  logic signed [PROD_W-1:0] prod;
  assign az_c = AZ - AZ_OFFSET;
  assign prod = PROD_W'(az_c) * PROD_W'(FUS_SCALE);
  assign ptch_acc = 16'(prod >>> 13);
  // Compared against the registered pitch, i.e. the value before this update.
  assign fusion = ptch_acc > ptch ? INT_W'(FUSION_GAIN) : -INT_W'(FUSION_GAIN);
`else
  logic unused_az;
  assign unused_az = ^{AZ, AZ_OFFSET, FUS_SCALE, FUSION_GAIN};
  assign fusion = '0;
`endif
  always_comb begin
    diff = 17'(ptch_rt_raw) - 17'(offset);
    comp = sat16(diff);
    int_sum = ACC_W'(int_q) - ACC_W'(comp) + ACC_W'(fusion);
    int_d = cal_strt ? '0 : upd ? sat_int(int_sum) : int_q;
    ptch_rt_d = cal_strt ? '0 : upd ? comp : ptch_rt_q;
    ptch_vld_d = upd;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_q <= '0;
      ptch_rt_q <= '0;
      ptch_vld_q <= 1'b0;
    end else begin
      int_q <= int_d;
      ptch_rt_q <= ptch_rt_d;
      ptch_vld_q <= ptch_vld_d;
    end
  end
endmodule

// File: tb/tb_inertial_integrator.sv
// tb_inertial_integrator: directed stimulus with a per-cycle arithmetic model of inertial_integrator.
module tb_inertial_integrator;
  logic clk = 0, rst_n = 1, vld = 0, cal_strt = 0;
  logic [15:0] raw = 0, az = 0;
  logic [15:0] ptch, ptch_rt;
  logic ptch_vld, cal_done;
  int pass = 0, total = 0, vcnt = 0;
  always #5 clk = ~clk;
  inertial_integrator dut (
    .clk(clk), .rst_n(rst_n), .vld(vld), .ptch_rt_raw(raw), .AZ(az), .cal_strt(cal_strt),
    .ptch(ptch), .ptch_rt(ptch_rt), .ptch_vld(ptch_vld), .cal_done(cal_done)
  );
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
  endtask
  function automatic int clamp(input int v, input int lo, input int hi);
    return v < lo ? lo : v > hi ? hi : v;
  endfunction
  // Model: calibration as a running integer sum, integration as plain clamped arithmetic.
  bit m_cal = 1, m_vld = 0;
  int m_cnt = 0, m_sum = 0, m_off = 0, m_int = 0, m_rt = 0, c, f, acc;
  logic [15:0] azd;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cal = 1; m_cnt = 0; m_sum = 0; m_off = 0; m_int = 0; m_rt = 0; m_vld = 0;
    end else if (cal_strt) begin
      m_cal = 1; m_cnt = 0; m_sum = 0; m_int = 0; m_rt = 0; m_vld = 0;
    end else if (vld && m_cal) begin
      m_sum = m_sum + int'($signed(raw));
      m_cnt++;
      m_vld = 0;
      if (m_cnt == 16) begin
        m_off = m_sum >>> 4;
        m_cal = 0; m_cnt = 0; m_sum = 0;
      end
    end else if (vld) begin
      c = clamp(int'($signed(raw)) - m_off, -32768, 32767);
      azd = az - 16'h00A0;
      acc = (int'($signed(azd)) * 327) >>> 13;
`ifdef INERT_FUSION_EN
      f = acc > (m_int >>> 11) ? 1024 : -1024;
`else
      f = 0;
`endif
      m_int = clamp(m_int - c + f, -(1 << 26), (1 << 26) - 1);
      m_rt = c;
      m_vld = 1;
    end else m_vld = 0;
  end
  always @(negedge clk) begin
    chk("m_ptch", ptch, 16'(m_int >>> 11));
    chk("m_ptch_rt", ptch_rt, 16'(m_rt));
    chk("m_ptch_vld", {15'b0, ptch_vld}, {15'b0, m_vld});
    chk("m_cal_done", {15'b0, cal_done}, {15'b0, !m_cal});
    if (ptch_vld) vcnt++;
  end
  task automatic pulse(input logic [15:0] r, input logic [15:0] a, input int n);
    vld = 1; raw = r; az = a;
    repeat (n) @(posedge clk);
    #1 vld = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic restart();
    cal_strt = 1;
    @(posedge clk);
    #1 cal_strt = 0;
  endtask
  initial begin
    #1 rst_n = 0;
    idle(3);
    chk("rst_ptch", ptch, 16'h0000);
    chk("rst_ptch_rt", ptch_rt, 16'h0000);
    chk("rst_vld", {15'b0, ptch_vld}, 16'h0000);
    chk("rst_done", {15'b0, cal_done}, 16'h0000);
    rst_n = 1;
    idle(1);
    vcnt = 0;
    pulse(16'h0050, 16'h0000, 15);
    chk("cal15_done", {15'b0, cal_done}, 16'h0000);
    pulse(16'h0050, 16'h0000, 1);
    chk("cal16_done", {15'b0, cal_done}, 16'h0001);
    idle(1);
    chk("cal_no_vld", 16'(vcnt), 16'd0);
    vcnt = 0;
    pulse(16'hF850, 16'h0000, 10);
    idle(1);
    chk("int_rt", ptch_rt, 16'hF800);
    chk("int_ptch10", ptch, 16'h000A);
    chk("int_vcnt10", 16'(vcnt), 16'd10);
    for (int i = 0; i < 3; i++) begin
      pulse(16'hF850, 16'h0000, 1);
      idle(2);
    end
    chk("int_ptch13", ptch, 16'h000D);
    chk("int_vcnt13", 16'(vcnt), 16'd13);
    cal_strt = 1;
    pulse(16'hF850, 16'h0000, 1);
    cal_strt = 0;
    chk("cs_vld", {15'b0, ptch_vld}, 16'h0000);
    chk("cs_ptch", ptch, 16'h0000);
    chk("cs_done", {15'b0, cal_done}, 16'h0000);
    vcnt = 0;
    for (int i = 0; i < 16; i++) begin
      pulse(16'h0050, 16'h0000, 1);
      idle(1);
    end
    chk("cs_no_vld", 16'(vcnt), 16'd0);
    chk("cs_done16", {15'b0, cal_done}, 16'h0001);
    pulse(16'h0050, 16'h00A0, 1);
`ifdef INERT_FUSION_EN
    chk("fus_1", ptch, 16'hFFFF);
`else
    chk("fus_1", ptch, 16'h0000);
`endif
    pulse(16'h0050, 16'h00A0, 1);
    chk("fus_2", ptch, 16'h0000);
    pulse(16'h0050, 16'h00A0, 4);
    pulse(16'h0050, 16'h20A0, 6);
    restart();
    pulse(16'h7FFF, 16'h00A0, 16);
    pulse(16'h8000, 16'h00A0, 1);
    chk("sat_rt_neg", ptch_rt, 16'h8000);
    pulse(16'h8000, 16'h00A0, 2100);
    chk("sat_ptch_max", ptch, 16'h7FFF);
    pulse(16'h8000, 16'h00A0, 50);
    chk("sat_no_wrap_max", ptch, 16'h7FFF);
    restart();
    pulse(16'h8000, 16'h00A0, 16);
    pulse(16'h7FFF, 16'h00A0, 2100);
    chk("sat_rt_pos", ptch_rt, 16'h7FFF);
    chk("sat_ptch_min", ptch, 16'h8000);
    pulse(16'h7FFF, 16'h00A0, 50);
    chk("sat_no_wrap_min", ptch, 16'h8000);
    restart();
    pulse(16'h0050, 16'h0000, 7);
    #3 rst_n = 0;
    #1;
    chk("arst_ptch", ptch, 16'h0000);
    chk("arst_rt", ptch_rt, 16'h0000);
    chk("arst_done", {15'b0, cal_done}, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1;
    pulse(16'h0010, 16'h0000, 15);
    chk("arst_cal15", {15'b0, cal_done}, 16'h0000);
    pulse(16'h0010, 16'h0000, 1);
    chk("arst_cal16", {15'b0, cal_done}, 16'h0001);
    pulse(16'h0030, 16'h0000, 1);
    chk("arst_new_off", ptch_rt, 16'h0020);
    idle(2);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
